// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam int P_DEFAULT = 6;
    localparam int I_DEFAULT = 24;

endpackage

// File: rtl/pc_next.sv
// Next program-counter calculation: sequential increment or branch target.
// The wrap flag reports only a sequential roll-over from the last word to 0.
module pc_next
    import fetch_pkg::*;
#(
    parameter int P = P_DEFAULT
) (
    input  logic [P-1:0] pc,
    input  logic [P-1:0] instr_addr,
    input  logic         branch_en,
    input  logic         branch_rel,
    input  logic [P-1:0] branch_target,
    output logic [P-1:0] next_pc,
    output logic         wrap
);

    // Select the redirect target or the incremented PC; all sums are modulo 2**P.
    always_comb begin
        next_pc = pc + P'(1);
        wrap    = 1'b0;
        if (branch_en) begin
            if (branch_rel) begin
                next_pc = instr_addr + branch_target;
            end else begin
                next_pc = branch_target;
            end
        end else begin
            wrap = (pc == {P{1'b1}});
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller sitting in front of program memory.
// Registers each fetched instruction together with the address it came from.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int           P          = P_DEFAULT,
    parameter int           I          = I_DEFAULT,
    parameter logic [P-1:0] RESET_ADDR = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         run,
    input  logic         stall,
    input  logic         halt_req,
    input  logic         branch_en,
    input  logic         branch_rel,
    input  logic [P-1:0] branch_target,
    input  logic [I-1:0] instruction,
    output logic [P-1:0] address,
    output logic [I-1:0] instr_q,
    output logic [P-1:0] instr_addr,
    output logic         instr_valid,
    output logic         pc_wrap,
    output logic [1:0]   state
);

    fetch_state_t cur_state;
    fetch_state_t next_state;
    logic         do_fetch;
    logic         do_branch;
    logic         clr_valid;
    logic [P-1:0] next_pc;
    logic         wrap;

    pc_next #(.P(P)) u_pc_next (
        .pc            (address),
        .instr_addr    (instr_addr),
        .branch_en     (branch_en),
        .branch_rel    (branch_rel),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .wrap          (wrap)
    );

    assign state = cur_state;

    // State register; HALT is only left through reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next state and datapath controls, priority halt > !run > stall > branch > increment.
    always_comb begin
        next_state = cur_state;
        do_fetch   = 1'b0;
        do_branch  = 1'b0;
        clr_valid  = 1'b0;
        case (cur_state)
            IDLE: begin
                if (halt_req) begin
                    next_state = HALT;
                    clr_valid  = 1'b1;
                end else if (run) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    next_state = HALT;
                    clr_valid  = 1'b1;
                end else if (!run) begin
                    next_state = IDLE;
                    clr_valid  = 1'b1;
                end else if (stall) begin
                    next_state = STALL;
                end else if (branch_en) begin
                    do_branch = 1'b1;
                end else begin
                    do_fetch = 1'b1;
                end
            end
            STALL: begin
                if (halt_req) begin
                    next_state = HALT;
                    clr_valid  = 1'b1;
                end else if (!run) begin
                    next_state = IDLE;
                    clr_valid  = 1'b1;
                end else if (!stall) begin
                    next_state = RUN;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // PC, instruction register and wrap pulse; a branch flushes the valid flag for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address     <= RESET_ADDR;
            instr_q     <= '0;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
            pc_wrap     <= 1'b0;
        end else begin
            pc_wrap <= 1'b0;
            if (do_fetch) begin
                instr_q     <= instruction;
                instr_addr  <= address;
                instr_valid <= 1'b1;
                address     <= next_pc;
                pc_wrap     <= wrap;
            end else if (do_branch) begin
                address     <= next_pc;
                instr_valid <= 1'b0;
            end else if (clr_valid) begin
                instr_valid <= 1'b0;
            end
        end
    end

endmodule
